fetch_sequencer: RTL

Program-counter sequencer for the 9-bit core. It drives the 8-bit PC into the combinational instruction ROM and takes back the 9-bit instruction word. It handles start/done handshaking with the testbench or host, stalls, taken branches (absolute or PC-relative) and halt detection, and counts retired instructions. It sits between the top-level control and the instruction ROM and decoder.

---
 rtl/fetch_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: walks the instruction ROM from a start address, handles
// stalls, absolute/relative branches and halt detection, and counts retired instructions.
module fetch_sequencer #(
   parameter int unsigned         PC_W    = 8,
   parameter int unsigned         INST_W  = 9,
   parameter logic [INST_W-1:0]   HALT_OP = 9'b111_111_111,
   parameter int unsigned         CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   input  logic [INST_W-1:0] inst_in,
   input  logic              stall,
   input  logic              br_taken,
   input  logic              br_abs,
   input  logic [PC_W-1:0]   br_target,
   output logic [PC_W-1:0]   PC,
   output logic              inst_valid,
   output logic              retire,
   output logic              done,
   output logic [CNT_W-1:0]  retired_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_t;

   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              is_halt;

   assign is_halt    = (inst_in == HALT_OP);
   assign inst_valid = (state_q == S_RUN);
   assign done       = (state_q == S_HALT);
   assign retire     = inst_valid & ~stall & ~is_halt;

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path can infer a latch.
      state_d = state_q;
      pc_d    = PC;
      cnt_d   = retired_cnt;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = start_addr;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // A stall freezes everything; a pending halt is seen again once it drops.
            if (!stall) begin
               if (is_halt) begin
                  state_d = S_HALT;
               end else begin
                  // Offset and PC share a width, so the wrapping add is the sign-extended sum.
                  if (br_taken) pc_d = br_abs ? br_target : PC + br_target;
                  else          pc_d = PC + PC_ONE;
                  if (retired_cnt != '1) cnt_d = retired_cnt + CNT_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments for all registered state.
      if (!reset_n) begin
         state_q     <= S_IDLE;
         PC          <= '0;
         retired_cnt <= '0;
      end else begin
         state_q     <= state_d;
         PC          <= pc_d;
         retired_cnt <= cnt_d;
      end
   end

endmodule
